// File: rtl/cmdq_issue_pkg.sv
// Shared types and constants for the cmdq/ximm1q issue controller.
// Holds the issue FSM states, default sizes and the credit-counter width helper.
package cmdq_issue_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } issue_state_e;

  localparam int DEF_CMDQ_DEPTH = 4;
  localparam int DEF_XIMM_DEPTH = 4;
  localparam int DEF_CMD_W      = 32;
  localparam int DEF_IMM_W      = 64;
  localparam int DEF_CNT_W      = 8;

  // A counter that must represent 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-queue credit counter: starts full, decrements on enqueue, increments on credit return.
// Flags a sticky error when a credit comes back while the counter is already full.
module credit_counter
  import cmdq_issue_pkg::*;
#(
  parameter int DEPTH = DEF_CMDQ_DEPTH,
  localparam int CW   = cred_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          nonzero,
  output logic          full,
  output logic          err
);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          err_r;
  logic          err_next_s;
  logic          full_s;
  logic          nonzero_s;

  assign full_s    = (cnt_r == CW'(DEPTH));
  assign nonzero_s = (cnt_r != {CW{1'b0}});

  // Next credit value; a return at full saturates and raises the error flag.
  always_comb begin
    cnt_next_s = cnt_r;
    err_next_s = err_r;
    if (dec && !inc && nonzero_s) begin
      cnt_next_s = cnt_r - CW'(1);
    end else if (inc && !dec && !full_s) begin
      cnt_next_s = cnt_r + CW'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
    if (inc && !dec && full_s) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = err_r;
    end
  end

  // Credit and error state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= CW'(DEPTH);
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      err_r <= err_next_s;
    end
  end

  assign cnt     = cnt_r;
  assign nonzero = nonzero_s;
  assign full    = full_s;
  assign err     = err_r;

endmodule

// File: rtl/cmdq_issue_ctrl.sv
// Credit-based issue scheduler feeding cmdq and ximm1q from the block decoder.
// Issues both enqueues of a command atomically, replays when credits are short, supports drain.
module cmdq_issue_ctrl
  import cmdq_issue_pkg::*;
#(
  parameter int CMDQ_DEPTH = DEF_CMDQ_DEPTH,
  parameter int XIMM_DEPTH = DEF_XIMM_DEPTH,
  parameter int CMD_W      = DEF_CMD_W,
  parameter int IMM_W      = DEF_IMM_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_valid,
  input  logic             io_sigs_enq_cmdq,
  input  logic             io_sigs_enq_ximm1q,
  input  logic [CMD_W-1:0] io_cmd_bits,
  input  logic [IMM_W-1:0] io_imm_bits,
  output logic             io_replay,
  output logic             io_cmdq_valid,
  output logic [CMD_W-1:0] io_cmdq_bits,
  output logic             io_ximm1q_valid,
  output logic [IMM_W-1:0] io_ximm1q_bits,
  input  logic             io_cmdq_deq,
  input  logic             io_ximm1q_deq,
  input  logic             io_drain_req,
  output logic             io_drain_done,
  output logic [CNT_W-1:0] io_replay_cnt,
  input  logic             io_cnt_clr,
  output logic             io_credit_err
);

  localparam int CMDQ_CW = cred_w(CMDQ_DEPTH);
  localparam int XIMM_CW = cred_w(XIMM_DEPTH);

  issue_state_e       state_r;
  issue_state_e       state_next_s;
  logic               ok_s;
  logic               accept_s;
  logic               replay_s;
  logic               issue_c_s;
  logic               issue_x_s;
  logic [CMDQ_CW-1:0] cmdq_cred_s;
  logic [XIMM_CW-1:0] ximm_cred_s;
  logic               cmdq_nz_s;
  logic               ximm_nz_s;
  logic               cmdq_full_s;
  logic               ximm_full_s;
  logic               cmdq_err_s;
  logic               ximm_err_s;
  logic               cmdq_valid_r;
  logic [CMD_W-1:0]   cmdq_bits_r;
  logic               ximm_valid_r;
  logic [IMM_W-1:0]   ximm_bits_r;
  logic [CNT_W-1:0]   replay_cnt_r;

  // Credits come from registers only, so a same-cycle return cannot unblock a command.
  assign ok_s      = (state_r == ST_RUN)
                   && (!io_sigs_enq_cmdq   || cmdq_nz_s)
                   && (!io_sigs_enq_ximm1q || ximm_nz_s);
  assign accept_s  = io_valid && ok_s;
  assign replay_s  = io_valid && !ok_s;
  assign issue_c_s = accept_s && io_sigs_enq_cmdq;
  assign issue_x_s = accept_s && io_sigs_enq_ximm1q;

  credit_counter #(.DEPTH(CMDQ_DEPTH)) u_cmdq_cred (
    .clk     (clk),
    .reset_n (reset_n),
    .dec     (issue_c_s),
    .inc     (io_cmdq_deq),
    .cnt     (cmdq_cred_s),
    .nonzero (cmdq_nz_s),
    .full    (cmdq_full_s),
    .err     (cmdq_err_s)
  );

  credit_counter #(.DEPTH(XIMM_DEPTH)) u_ximm_cred (
    .clk     (clk),
    .reset_n (reset_n),
    .dec     (issue_x_s),
    .inc     (io_ximm1q_deq),
    .cnt     (ximm_cred_s),
    .nonzero (ximm_nz_s),
    .full    (ximm_full_s),
    .err     (ximm_err_s)
  );

  // Issue FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Drain follows the request level; leaving drain does not wait for completion.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (io_drain_req) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!io_drain_req) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // Enqueue pulses and payload registers; payloads only move when their queue is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmdq_valid_r <= 1'b0;
      ximm_valid_r <= 1'b0;
      cmdq_bits_r  <= {CMD_W{1'b0}};
      ximm_bits_r  <= {IMM_W{1'b0}};
    end else begin
      cmdq_valid_r <= issue_c_s;
      ximm_valid_r <= issue_x_s;
      if (issue_c_s) begin
        cmdq_bits_r <= io_cmd_bits;
      end
      if (issue_x_s) begin
        ximm_bits_r <= io_imm_bits;
      end
    end
  end

  // Saturating replay-cycle counter; clear wins over a concurrent replay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      replay_cnt_r <= {CNT_W{1'b0}};
    end else if (io_cnt_clr) begin
      replay_cnt_r <= {CNT_W{1'b0}};
    end else if (replay_s && (replay_cnt_r != {CNT_W{1'b1}})) begin
      replay_cnt_r <= replay_cnt_r + CNT_W'(1);
    end
  end

  assign io_replay       = replay_s;
  assign io_cmdq_valid   = cmdq_valid_r;
  assign io_cmdq_bits    = cmdq_bits_r;
  assign io_ximm1q_valid = ximm_valid_r;
  assign io_ximm1q_bits  = ximm_bits_r;
  assign io_drain_done   = (state_r == ST_DRAIN) && cmdq_full_s && ximm_full_s;
  assign io_replay_cnt   = replay_cnt_r;
  assign io_credit_err   = cmdq_err_s || ximm_err_s;

endmodule

// File: tb/tb_cmdq_issue_ctrl.sv
// Directed bench for cmdq_issue_ctrl with hand-computed expectations.
module tb_cmdq_issue_ctrl;

  logic        clk;
  logic        reset_n;
  logic        io_valid;
  logic        io_sigs_enq_cmdq;
  logic        io_sigs_enq_ximm1q;
  logic [31:0] io_cmd_bits;
  logic [63:0] io_imm_bits;
  logic        io_replay;
  logic        io_cmdq_valid;
  logic [31:0] io_cmdq_bits;
  logic        io_ximm1q_valid;
  logic [63:0] io_ximm1q_bits;
  logic        io_cmdq_deq;
  logic        io_ximm1q_deq;
  logic        io_drain_req;
  logic        io_drain_done;
  logic [7:0]  io_replay_cnt;
  logic        io_cnt_clr;
  logic        io_credit_err;

  int n_checks;
  int n_fail;

  cmdq_issue_ctrl dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .io_valid           (io_valid),
    .io_sigs_enq_cmdq   (io_sigs_enq_cmdq),
    .io_sigs_enq_ximm1q (io_sigs_enq_ximm1q),
    .io_cmd_bits        (io_cmd_bits),
    .io_imm_bits        (io_imm_bits),
    .io_replay          (io_replay),
    .io_cmdq_valid      (io_cmdq_valid),
    .io_cmdq_bits       (io_cmdq_bits),
    .io_ximm1q_valid    (io_ximm1q_valid),
    .io_ximm1q_bits     (io_ximm1q_bits),
    .io_cmdq_deq        (io_cmdq_deq),
    .io_ximm1q_deq      (io_ximm1q_deq),
    .io_drain_req       (io_drain_req),
    .io_drain_done      (io_drain_done),
    .io_replay_cnt      (io_replay_cnt),
    .io_cnt_clr         (io_cnt_clr),
    .io_credit_err      (io_credit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n            = 1'b0;
    io_valid           = 1'b0;
    io_sigs_enq_cmdq   = 1'b0;
    io_sigs_enq_ximm1q = 1'b0;
    io_cmd_bits        = 32'h0;
    io_imm_bits        = 64'h0;
    io_cmdq_deq        = 1'b0;
    io_ximm1q_deq      = 1'b0;
    io_drain_req       = 1'b0;
    io_cnt_clr         = 1'b0;

    // Reset state
    #12;
    chk("rst_cvalid", 64'(io_cmdq_valid), 64'd0);
    chk("rst_xvalid", 64'(io_ximm1q_valid), 64'd0);
    chk("rst_cbits", 64'(io_cmdq_bits), 64'd0);
    chk("rst_xbits", io_ximm1q_bits, 64'd0);
    chk("rst_cnt", 64'(io_replay_cnt), 64'd0);
    chk("rst_err", 64'(io_credit_err), 64'd0);
    chk("rst_done", 64'(io_drain_done), 64'd0);
    chk("rst_ccred", 64'(dut.u_cmdq_cred.cnt), 64'd4);
    chk("rst_xcred", 64'(dut.u_ximm_cred.cnt), 64'd4);
    reset_n = 1'b1;

    // Four back-to-back dual-queue commands, then a fifth that must replay
    io_sigs_enq_cmdq   = 1'b1;
    io_sigs_enq_ximm1q = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_valid    = 1'b1;
      io_cmd_bits = 32'h100 + 32'(i);
      io_imm_bits = 64'h1000 + 64'(i);
      #1;
      chk("b2b_replay", 64'(io_replay), 64'd0);
      tick();
      chk("b2b_cvalid", 64'(io_cmdq_valid), 64'd1);
      chk("b2b_xvalid", 64'(io_ximm1q_valid), 64'd1);
      chk("b2b_cbits", 64'(io_cmdq_bits), 64'h100 + 64'(i));
      chk("b2b_xbits", io_ximm1q_bits, 64'h1000 + 64'(i));
    end
    chk("b2b_ccred0", 64'(dut.u_cmdq_cred.cnt), 64'd0);
    chk("b2b_xcred0", 64'(dut.u_ximm_cred.cnt), 64'd0);
    io_cmd_bits = 32'hDEAD;
    #1;
    chk("fifth_replay", 64'(io_replay), 64'd1);
    tick();
    chk("fifth_cvalid", 64'(io_cmdq_valid), 64'd0);
    chk("fifth_xvalid", 64'(io_ximm1q_valid), 64'd0);
    chk("fifth_cnt", 64'(io_replay_cnt), 64'd1);
    chk("fifth_cbits", 64'(io_cmdq_bits), 64'h103);
    io_valid = 1'b0;

    // Return all ximm1q credits: creds become 0/4
    io_ximm1q_deq = 1'b1;
    repeat (4) tick();
    io_ximm1q_deq = 1'b0;
    chk("xret_cred", 64'(dut.u_ximm_cred.cnt), 64'd4);
    chk("xret_err", 64'(io_credit_err), 64'd0);

    // cmdq-only command replays; ximm1q-only command is accepted
    io_valid           = 1'b1;
    io_sigs_enq_cmdq   = 1'b1;
    io_sigs_enq_ximm1q = 1'b0;
    #1;
    chk("conly_replay", 64'(io_replay), 64'd1);
    tick();
    io_sigs_enq_cmdq   = 1'b0;
    io_sigs_enq_ximm1q = 1'b1;
    io_imm_bits        = 64'hABC;
    #1;
    chk("xonly_replay", 64'(io_replay), 64'd0);
    tick();
    io_valid = 1'b0;
    chk("xonly_xvalid", 64'(io_ximm1q_valid), 64'd1);
    chk("xonly_cvalid", 64'(io_cmdq_valid), 64'd0);
    chk("xonly_xbits", io_ximm1q_bits, 64'hABC);
    chk("xonly_cbits", 64'(io_cmdq_bits), 64'h103);
    chk("xonly_xcred", 64'(dut.u_ximm_cred.cnt), 64'd3);
    chk("xonly_cnt", 64'(io_replay_cnt), 64'd2);

    // Same-cycle credit return does not unblock; accepted on the next cycle
    io_valid           = 1'b1;
    io_sigs_enq_cmdq   = 1'b1;
    io_sigs_enq_ximm1q = 1'b0;
    io_cmd_bits        = 32'h55;
    io_cmdq_deq        = 1'b1;
    #1;
    chk("samecyc_replay", 64'(io_replay), 64'd1);
    tick();
    io_cmdq_deq = 1'b0;
    #1;
    chk("nextcyc_replay", 64'(io_replay), 64'd0);
    tick();
    io_valid = 1'b0;
    chk("nextcyc_cvalid", 64'(io_cmdq_valid), 64'd1);
    chk("nextcyc_cbits", 64'(io_cmdq_bits), 64'h55);
    chk("nextcyc_ccred", 64'(dut.u_cmdq_cred.cnt), 64'd0);

    // Bring creds to cmdq=2 (2 outstanding), ximm1q=4
    io_cmdq_deq   = 1'b1;
    io_ximm1q_deq = 1'b1;
    tick();
    io_ximm1q_deq = 1'b0;
    tick();
    io_cmdq_deq = 1'b0;
    chk("pre_drain_ccred", 64'(dut.u_cmdq_cred.cnt), 64'd2);
    chk("pre_drain_xcred", 64'(dut.u_ximm_cred.cnt), 64'd4);

    // Drain: commands replay, done only after outstanding credits return
    io_drain_req = 1'b1;
    tick();
    chk("drain_done0", 64'(io_drain_done), 64'd0);
    io_valid = 1'b1;
    #1;
    chk("drain_replay", 64'(io_replay), 64'd1);
    tick();
    io_valid = 1'b0;
    chk("drain_cvalid", 64'(io_cmdq_valid), 64'd0);
    chk("drain_cnt", 64'(io_replay_cnt), 64'd4);
    io_cmdq_deq = 1'b1;
    tick();
    chk("drain_done1", 64'(io_drain_done), 64'd0);
    tick();
    io_cmdq_deq = 1'b0;
    chk("drain_done2", 64'(io_drain_done), 64'd1);
    io_drain_req = 1'b0;
    tick();
    chk("undrain_done", 64'(io_drain_done), 64'd0);
    io_valid    = 1'b1;
    io_cmd_bits = 32'h77;
    #1;
    chk("resume_replay", 64'(io_replay), 64'd0);
    tick();
    io_valid = 1'b0;
    chk("resume_cvalid", 64'(io_cmdq_valid), 64'd1);
    chk("resume_cbits", 64'(io_cmdq_bits), 64'h77);
    tick();
    chk("resume_pulse_end", 64'(io_cmdq_valid), 64'd0);

    // cmdq cred is 3: one return fills it cleanly, the next is an error
    io_cmdq_deq = 1'b1;
    tick();
    chk("fill_err", 64'(io_credit_err), 64'd0);
    chk("fill_ccred", 64'(dut.u_cmdq_cred.cnt), 64'd4);
    tick();
    io_cmdq_deq = 1'b0;
    chk("over_err", 64'(io_credit_err), 64'd1);
    chk("over_ccred", 64'(dut.u_cmdq_cred.cnt), 64'd4);
    tick();
    chk("sticky_err", 64'(io_credit_err), 64'd1);

    // Async reset between edges in the middle of a burst
    io_valid           = 1'b1;
    io_sigs_enq_cmdq   = 1'b1;
    io_sigs_enq_ximm1q = 1'b1;
    io_cmd_bits        = 32'h99;
    io_imm_bits        = 64'h999;
    tick();
    chk("burst_cvalid", 64'(io_cmdq_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cvalid", 64'(io_cmdq_valid), 64'd0);
    chk("arst_xvalid", 64'(io_ximm1q_valid), 64'd0);
    chk("arst_cbits", 64'(io_cmdq_bits), 64'd0);
    chk("arst_err", 64'(io_credit_err), 64'd0);
    chk("arst_cnt", 64'(io_replay_cnt), 64'd0);
    chk("arst_ccred", 64'(dut.u_cmdq_cred.cnt), 64'd4);
    chk("arst_xcred", 64'(dut.u_ximm_cred.cnt), 64'd4);
    io_valid = 1'b0;
    #1;
    reset_n = 1'b1;

    // Replay counter saturation and clear priority
    io_drain_req = 1'b1;
    tick();
    io_valid = 1'b1;
    repeat (300) tick();
    chk("sat_cnt", 64'(io_replay_cnt), 64'd255);
    chk("sat_replay", 64'(io_replay), 64'd1);
    io_cnt_clr = 1'b1;
    tick();
    io_cnt_clr = 1'b0;
    chk("clr_cnt", 64'(io_replay_cnt), 64'd0);
    tick();
    chk("after_clr_cnt", 64'(io_replay_cnt), 64'd1);
    io_valid     = 1'b0;
    io_drain_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmdq_issue_ctrl.md
Name: cmdq_issue_ctrl

Overview:
- Sequences decoded vector commands into two downstream queues, cmdq and ximm1q, using per-queue credit counters.
- A decoded command is accepted only when every queue it targets has a free slot; otherwise the block asserts io_replay.
- Sits between the block decoder (enq_cmdq / enq_ximm1q sigs) and the queue pair. Replaces the free-running "not ready → replay" logic with an explicit scheduler.
- Also provides a drain handshake for context switch or fence, and counts replay cycles for performance monitoring.

Parameters:
- CMDQ_DEPTH, 4, cmdq entries; initial and maximum cmdq credits (≥1).
- XIMM_DEPTH, 4, ximm1q entries; initial and maximum ximm1q credits (≥1).
- CMD_W, 32, command payload width.
- IMM_W, 64, immediate payload width.
- CNT_W, 8, replay counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- io_valid  in  1  decoded command present this cycle
- io_sigs_enq_cmdq  in  1  command targets cmdq
- io_sigs_enq_ximm1q  in  1  command targets ximm1q
- io_cmd_bits  in  CMD_W  cmdq payload
- io_imm_bits  in  IMM_W  ximm1q payload
- io_replay  out  1  command not accepted this cycle
- io_cmdq_valid  out  1  enqueue pulse to cmdq
- io_cmdq_bits  out  CMD_W  registered cmdq payload
- io_ximm1q_valid  out  1  enqueue pulse to ximm1q
- io_ximm1q_bits  out  IMM_W  registered ximm1q payload
- io_cmdq_deq  in  1  one cmdq entry freed (credit return)
- io_ximm1q_deq  in  1  one ximm1q entry freed (credit return)
- io_drain_req  in  1  request to stop issue and empty both queues
- io_drain_done  out  1  both queues empty while draining
- io_replay_cnt  out  CNT_W  saturating replay-cycle count
- io_cnt_clr  in  1  synchronous clear of io_replay_cnt
- io_credit_err  out  1  sticky: credit return seen with credits already full

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=RUN; cmdq_cred=CMDQ_DEPTH; ximm_cred=XIMM_DEPTH.
  - All valid outputs, io_drain_done and io_credit_err are 0; io_replay_cnt=0; bits registers are 0.
- need_c = io_sigs_enq_cmdq; need_x = io_sigs_enq_ximm1q.
- ok = state==RUN && (!need_c || cmdq_cred!=0) && (!need_x || ximm_cred!=0). Credits are sampled from registers only; a same-cycle deq does not enable accept.
- accept = io_valid && ok.
- io_replay = io_valid && !ok. This output is combinational, so the decoder sees it in the same cycle.
- A command with need_c=need_x=0 and io_valid=1 in RUN is accepted with no enqueue, as a NOP.
- Issue timing (1-cycle latency):
  - On accept, next cycle io_cmdq_valid=need_c and io_ximm1q_valid=need_x.
  - Each bits register loads its payload only when its queue is enqueued.
  - Both enqueues of one command are issued atomically, in the same cycle. A partial issue is never allowed.
  - Valid outputs are single-cycle pulses; back-to-back accepts give back-to-back pulses.
- Credit update, per queue: cred_next = cred − (accept && need) + deq.
  - Simultaneous accept and deq leaves the credit unchanged.
  - deq while cred==DEPTH with no decrement that cycle: credit holds at DEPTH and io_credit_err sets. It clears only on reset.
- Replay counter:
  - Increments by 1 on each io_replay cycle and saturates at 2^CNT_W−1.
  - io_cnt_clr has priority over increment and sets the counter to 0.
- FSM:
  - RUN → DRAIN when io_drain_req=1. The command presented in that same cycle is still evaluated in RUN.
  - DRAIN: no accept; io_valid gives io_replay=1. Credit returns still count.
  - io_drain_done = (state==DRAIN) && cmdq_cred==CMDQ_DEPTH && ximm_cred==XIMM_DEPTH. It is combinational from registered state.
  - DRAIN → RUN when io_drain_req=0, whether or not draining has completed.
  - Enqueue pulses already registered before entering DRAIN still emit.

Decomposition:
- Shared package cmdq_issue_pkg holds:
  - the state enum (RUN, DRAIN);
  - the credit width function clog2(DEPTH+1);
  - default depth constants.
- One sub-module, credit_counter, instantiated twice. Interface: DEPTH parameter; inputs dec, inc; outputs cnt, nonzero, full, err.

Test Plan:
- Reset, then io_valid=1 with need_c=1 and need_x=1, 4 times back-to-back → 4 cmdq and 4 ximm1q pulses starting cycle+1, both creds=0. 5th command → io_replay=1, io_replay_cnt=1.
- Creds 0/4; cmd with need_c=1, need_x=0 → replay. Same cmd with need_c=0, need_x=1 → accepted; ximm1q pulse only; ximm_cred=3.
- cmdq_cred=0 with io_cmdq_deq and io_valid (need_c) in the same cycle → replay that cycle; accepted the next cycle.
- Assert io_drain_req with 2 cmdq credits outstanding → io_replay on io_valid, io_drain_done=0. After 2 deq pulses → io_drain_done=1. Drop req → RUN, accept resumes.
- io_cmdq_deq at full credit → io_credit_err=1 and stays 1; cred stays 4. Async reset mid-burst (reset_n low between edges) → outputs 0 immediately; creds reload to DEPTH.
- Force 300 replay cycles with CNT_W=8 → count 255 saturates. io_cnt_clr together with a replay → next value 0.
